// File: rtl/pulse_seq_gen.sv
// Transmitter for the a/b/finished pulse interface: one a pulse, num_b b pulses,
// an optional trailing a pulse and a finished pulse, each followed by a low gap.
module pulse_seq_gen #(
    parameter int PULSE_W = 2,
    parameter int GAP_W   = 2,
    parameter int CNT_W   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] num_b,
    input  logic             end_with_a,
    output logic             a,
    output logic             b,
    output logic             finished,
    output logic             busy,
    output logic             done
);

    localparam int MAX_W = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
    localparam int PH_W  = $clog2(MAX_W) + 1;

    localparam logic [PH_W-1:0] HI_LAST  = PH_W'(PULSE_W - 1);
    localparam logic [PH_W-1:0] GAP_LAST = PH_W'(GAP_W - 1);
    localparam logic [PH_W-1:0] PH_SAT   = PH_W'(MAX_W - 1);

    typedef enum logic [3:0] {
        IDLE,
        A_HI,
        A_GAP,
        B_HI,
        B_GAP,
        A2_HI,
        A2_GAP,
        FIN_HI,
        FIN_GAP
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [PH_W-1:0]  phase;
    logic [CNT_W-1:0] b_cnt;
    logic [CNT_W-1:0] num_b_q;
    logic             end_with_a_q;

    logic   hi_last;
    logic   gap_last;
    logic   accept;
    state_t after_b;

    always_comb begin
        // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latch).
        hi_last    = (phase == HI_LAST);
        gap_last   = (phase == GAP_LAST);
        accept     = (state == IDLE) && start;
        after_b    = end_with_a_q ? A2_HI : FIN_HI;
        state_next = state;

        unique case (state)
            IDLE:    if (start)    state_next = A_HI;
            A_HI:    if (hi_last)  state_next = A_GAP;
            A_GAP:   if (gap_last) state_next = (num_b_q != '0) ? B_HI : after_b;
            B_HI:    if (hi_last)  state_next = B_GAP;
            B_GAP:   if (gap_last) state_next = (b_cnt < num_b_q) ? B_HI : after_b;
            A2_HI:   if (hi_last)  state_next = A2_GAP;
            A2_GAP:  if (gap_last) state_next = FIN_HI;
            FIN_HI:  if (hi_last)  state_next = FIN_GAP;
            FIN_GAP: if (gap_last) state_next = IDLE;
            default:               state_next = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state        <= IDLE;
            phase        <= '0;
            b_cnt        <= '0;
            num_b_q      <= '0;
            end_with_a_q <= 1'b0;
            a            <= 1'b0;
            b            <= 1'b0;
            finished     <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            state <= state_next;

            if (state_next != state) begin
                phase <= '0;
            end else if (phase != PH_SAT) begin
                phase <= phase + PH_W'(1);
            end

            if (accept) begin
                num_b_q      <= num_b;
                end_with_a_q <= end_with_a;
                b_cnt        <= '0;
            end else if (state == B_HI && hi_last && b_cnt != '1) begin
                b_cnt <= b_cnt + CNT_W'(1);
            end

            a        <= (state_next == A_HI) || (state_next == A2_HI);
            b        <= (state_next == B_HI);
            finished <= (state_next == FIN_HI);
            busy     <= (state_next != IDLE);
            done     <= (state == FIN_GAP) && (state_next == IDLE);
        end
    end

endmodule

// File: tb/tb_pulse_seq_gen.sv
// Self-checking bench for pulse_seq_gen: directed scenarios plus randomized sequences
// compared cycle by cycle against an arithmetic model of the pulse train.
module tb_pulse_seq_gen;

    localparam int P  = 2;
    localparam int G  = 2;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [CW-1:0] num_b;
    logic          end_with_a;
    logic          a;
    logic          b;
    logic          finished;
    logic          busy;
    logic          done;

    int checks   = 0;
    int failures = 0;

    pulse_seq_gen #(
        .PULSE_W(P),
        .GAP_W  (G),
        .CNT_W  (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .num_b     (num_b),
        .end_with_a(end_with_a),
        .a         (a),
        .b         (b),
        .finished  (finished),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input bit ea, input bit eb, input bit ef,
                                 input bit ebusy, input bit edone);
        check({tag, ".a"}, 32'(a), 32'(ea));
        check({tag, ".b"}, 32'(b), 32'(eb));
        check({tag, ".finished"}, 32'(finished), 32'(ef));
        check({tag, ".busy"}, 32'(busy), 32'(ebusy));
        check({tag, ".done"}, 32'(done), 32'(edone));
        check({tag, ".excl"}, 32'(int'(a) + int'(b) + int'(finished) <= 1), 32'd1);
    endtask

    // The sequence is a list of pulses, each occupying P+G cycles starting at cycle 1.
    // Pulse 0 is a, pulses 1..n are b, then an optional a, then finished.
    function automatic void model(input int n, input bit e, input int k,
                                  output bit ea, output bit eb, output bit ef,
                                  output bit ebusy, output bit edone);
        int total;
        int idx;
        bit hi;
        total = (2 + n + int'(e)) * (P + G);
        ebusy = (k >= 1) && (k <= total);
        edone = (k == total + 1);
        ea = 1'b0;
        eb = 1'b0;
        ef = 1'b0;
        if (ebusy) begin
            idx = (k - 1) / (P + G);
            hi  = ((k - 1) % (P + G)) < P;
            if (hi) begin
                if (idx == 0)                 ea = 1'b1;
                else if (idx <= n)            eb = 1'b1;
                else if (e && idx == n + 1)   ea = 1'b1;
                else                          ef = 1'b1;
            end
        end
    endfunction

    // Called while the DUT sits in IDLE; returns in the done cycle (or after a reset abort).
    task automatic run_seq(input int n, input bit e, input bit hold, input int restart_k,
                           input int nbchg_k, input int rst_k, input string tag);
        int total;
        bit ea, eb, ef, ebusy, edone;
        total      = (2 + n + int'(e)) * (P + G);
        num_b      = CW'(n);
        end_with_a = e;
        start      = 1'b1;
        tick();
        if (!hold) start = 1'b0;
        for (int k = 1; k <= total + 1; k++) begin
            model(n, e, k, ea, eb, ef, ebusy, edone);
            check_outputs($sformatf("%s@%0d", tag, k), ea, eb, ef, ebusy, edone);
            if (k == rst_k) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
                for (int j = 0; j < 4; j++) begin
                    check_outputs($sformatf("%s.after_rst+%0d", tag, j), 0, 0, 0, 0, 0);
                    tick();
                end
                return;
            end
            if (!hold) start = (k == restart_k);
            if (k == nbchg_k) num_b = CW'(1);
            if (k <= total) tick();
        end
    endtask

    task automatic idle_cycles(input int cnt, input string tag);
        for (int j = 0; j < cnt; j++) begin
            tick();
            check_outputs($sformatf("%s.idle%0d", tag, j), 0, 0, 0, 0, 0);
        end
    endtask

    initial begin
        int n;
        bit e;
        rst        = 1'b1;
        start      = 1'b0;
        num_b      = '0;
        end_with_a = 1'b0;
        tick();
        tick();
        check_outputs("reset", 0, 0, 0, 0, 0);
        rst = 1'b0;
        idle_cycles(2, "post_reset");

        run_seq(3, 1'b0, 1'b0, -1, -1, -1, "s1");
        idle_cycles(2, "s1");
        run_seq(2, 1'b1, 1'b0, -1, -1, -1, "s2");
        idle_cycles(1, "s2");
        run_seq(0, 1'b0, 1'b0, -1, -1, -1, "s3");
        idle_cycles(1, "s3");
        run_seq(3, 1'b0, 1'b0, 7, 3, -1, "s4");
        idle_cycles(3, "s4");
        run_seq(3, 1'b0, 1'b0, -1, -1, 10, "s5_abort");
        run_seq(3, 1'b0, 1'b0, -1, -1, -1, "s5_replay");
        idle_cycles(1, "s5");

        run_seq(1, 1'b0, 1'b1, -1, -1, -1, "s6_first");
        run_seq(1, 1'b0, 1'b1, -1, -1, -1, "s6_second");
        run_seq(1, 1'b0, 1'b0, -1, -1, -1, "s6_third");
        idle_cycles(1, "s6");

        run_seq((1 << CW) - 1, 1'b1, 1'b0, -1, -1, -1, "max_b");
        idle_cycles(1, "max_b");

        // Back-to-back from the done cycle with no idle gap.
        run_seq(0, 1'b1, 1'b0, -1, -1, -1, "b2b_a");
        run_seq(4, 1'b0, 1'b0, -1, -1, -1, "b2b_b");
        idle_cycles(1, "b2b");

        for (int it = 0; it < 25; it++) begin
            n = int'($urandom_range((1 << CW) - 1, 0));
            e = 1'($urandom_range(1, 0));
            run_seq(n, e, 1'b0, int'($urandom_range(12, 2)), int'($urandom_range(12, 2)), -1,
                    $sformatf("rnd%0d", it));
            idle_cycles(int'($urandom_range(2, 0)), $sformatf("rnd%0d", it));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
